// File: rtl/pipe_pkg.sv
// Shared widths for the inter-stage pipeline bundles so every stage packs its
// control fields identically.
package pipe_pkg;

  localparam int PIPE_DATA_W     = 32;
  localparam int PIPE_CNT_W      = 16;

  // Control-field widths carried alongside the payload at each boundary.
  localparam int CTRL_IF_ID_W    = 1;
  localparam int CTRL_ID_EX_W    = 17;
  localparam int CTRL_EX_MEM_W   = 7;
  localparam int CTRL_MEM_WB_W   = 3;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
// Count updates one cycle after inc/clr; no handshake.
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with a skid slot, flush and stall counter.
// Latency 1 cycle; in_ready comes from the skid flop, so backpressure never combs through.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W      = PIPE_DATA_W,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_W       = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] main_dat_q, main_dat_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic              in_fire, out_fire;

  assign in_ready  = ~skid_vld_q;
  assign out_valid = main_vld_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = (ZERO_BUBBLE && !main_vld_q) ? '0 : main_dat_q;

  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (!main_vld_q || out_fire) begin
      // Skid beat is older than anything on the input, so it drains first.
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = skid_dat_q;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        main_vld_d = 1'b1;
        main_dat_d = in_data;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_data;
    end
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
      main_dat_d = main_dat_q;
      skid_dat_d = skid_dat_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_dat_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_dat_q <= main_dat_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  pipe_sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(main_vld_q & ~out_ready),
    .clr(cnt_clr),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: scoreboard on every output beat plus per-scenario checks.
module tb_pipe_stage_hs;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        cnt_clr;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] stall_cnt;
  logic        in_ready4, out_valid4;
  logic [31:0] out_data4;
  logic [3:0]  stall_cnt4;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_dat;

  pipe_stage_hs #(.DATA_W(32), .ZERO_BUBBLE(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  pipe_stage_hs #(.DATA_W(32), .ZERO_BUBBLE(1'b1), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_beat got=%h required=none", out_data);
        end else begin
          sb_exp = sb_q.pop_front();
          if (out_data !== sb_exp) begin
            failures++;
            $display("FAIL sb_beat got=%h required=%h", out_data, sb_exp);
          end
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(in_data);
    end
  end

  // Upstream must hold a refused beat until it is taken (flush/reset release it).
  always @(negedge clk) begin
    if (rst_n && hold_pend)
      assert (in_valid && in_data == hold_dat) else $error("upstream dropped a pending beat");
    hold_pend = rst_n && !flush && in_valid && !in_ready;
    hold_dat  = in_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    out_ready = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    #2;
    step(); step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h required=0", out_data); end
    checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL rst_stall_cnt got=%0d required=0", stall_cnt); end
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rst_first_beat got=%b/%h required=1/deadbeef", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready beat=%0d got=%b required=1", i, in_ready); end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        failures++; $display("FAIL stream_out beat=%0d got=%b/%h required=1/%h", i, out_valid, out_data, 32'(i));
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_end got=%b required=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; cnt_clr = 1'b1; in_valid = 1'b1; in_data = 32'hA;
    step();
    cnt_clr = 1'b0; in_data = 32'hB;
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_after_b got=%b required=0", in_ready); end
    in_data = 32'hC;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_held got=%b required=0", in_ready); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA) begin
      failures++; $display("FAIL bp_main_a got=%b/%h required=1/a", out_valid, out_data);
    end
    checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall_cnt got=%0d required=3", stall_cnt); end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 32'hB) begin failures++; $display("FAIL bp_out_b got=%h required=b", out_data); end
    step();
    checks++; if (out_data !== 32'hC) begin failures++; $display("FAIL bp_out_c got=%h required=c", out_data); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b required=0", out_valid); end
    checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall_final got=%0d required=3", stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    flush = 1'b1; in_data = 32'hD;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b required=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b required=1", in_ready); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL flush_bubble_data got=%h required=0", out_data); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hE;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hE) begin
      failures++; $display("FAIL flush_e got=%b/%h required=1/e", out_valid, out_data);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_e_alone got=%b required=0", out_valid); end
    // A beat accepted in the flush cycle is discarded.
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_accept_drop got=%b required=0", out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0; cnt_clr = 1'b1; in_valid = 1'b1; in_data = 32'h55;
    step();
    cnt_clr = 1'b0; in_valid = 1'b0;
    repeat (20) step();
    checks++; if (stall_cnt4 !== 4'd15) begin failures++; $display("FAIL sat_reach got=%0d required=15", stall_cnt4); end
    repeat (3) step();
    checks++; if (stall_cnt4 !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d required=15", stall_cnt4); end
    checks++; if (stall_cnt !== 16'd23) begin failures++; $display("FAIL sat_wide got=%0d required=23", stall_cnt); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (stall_cnt4 !== 4'd0) begin failures++; $display("FAIL sat_clr got=%0d required=0", stall_cnt4); end
    step();
    checks++; if (stall_cnt4 !== 4'd1) begin failures++; $display("FAIL sat_after_clr got=%0d required=1", stall_cnt4); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_drain got=%b required=0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h21;
    step();
    in_data = 32'h22;
    step();
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b required=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%b required=1", in_ready); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL arst_stall_cnt got=%0d required=0", stall_cnt); end
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_no_beat cycle=%0d got=%b required=0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_async_reset();
    step();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
